// File: rtl/x_settle_monitor_pkg.sv
// Shared types for the X-settle observation stage: FSM states and the
// three-valued encoding used for netlist outputs.
package x_settle_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OBSERVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One netlist output: x=1 means unknown, val is meaningful only when x=0.
  typedef struct packed {
    logic x;
    logic val;
  } tri_val_t;

endpackage

// File: rtl/x_sticky_tracker.sv
// Per-signal sticky history: has the signal ever been X, has it ever been
// known, and has it gone from known back to X inside the current window.
module x_sticky_tracker
  import x_settle_monitor_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     en,
  input  tri_val_t sig,
  output logic     x_seen,
  output logic     relapse
);

  logic known_once;

  // The value bit is carried for debug visibility only and never drives state.
  logic unused_val;
  assign unused_val = sig.val;

  // Accumulate X history while observing; clear on reset or a new window.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; relapse below depends on the old known_once.
    if (rst || clr) begin
      x_seen     <= 1'b0;
      known_once <= 1'b0;
      relapse    <= 1'b0;
    end else if (en) begin
      x_seen     <= x_seen | sig.x;
      known_once <= known_once | ~sig.x;
      relapse    <= relapse | (known_once & sig.x);
    end
  end

endmodule

// File: rtl/x_settle_monitor.sv
// Watches a netlist's outputs after a start request and reports whether the
// required ones settle to known values (and when) or stay stuck at X.
module x_settle_monitor
  import x_settle_monitor_pkg::*;
#(
  parameter int N_SIG       = 6,
  parameter int SETTLE_HOLD = 2,
  parameter int STUCK_LIMIT = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_SIG-1:0] sig_val,
  input  logic [N_SIG-1:0] sig_x,
  input  logic [N_SIG-1:0] must_settle,
  output logic             busy,
  output logic             done,
  output logic             settled,
  output logic [CNT_W-1:0] settle_cycles,
  output logic [N_SIG-1:0] stuck_mask,
  output logic [N_SIG-1:0] x_seen_mask,
  output logic [N_SIG-1:0] relapse_mask
);

  if (SETTLE_HOLD < 1 || STUCK_LIMIT < SETTLE_HOLD ||
      64'(STUCK_LIMIT) >= (64'd1 << CNT_W) || N_SIG < 1) begin : g_bad_params
    $error("x_settle_monitor: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(SETTLE_HOLD);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STUCK_LIMIT);

  state_t                 state;
  logic [N_SIG-1:0]       req_mask;
  logic [CNT_W-1:0]       cyc_cnt;
  logic [CNT_W-1:0]       hold_cnt;
  logic [CNT_W-1:0]       cyc_next;
  logic [CNT_W-1:0]       hold_next;
  logic                   all_known;
  logic                   accept;
  tri_val_t [N_SIG-1:0]   obs;

  assign accept = (state == IDLE) && start;

  // Next-cycle counter values for the current observation cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    cyc_next  = cyc_cnt + CNT_ONE;
    all_known = ((sig_x & req_mask) == '0);
    hold_next = '0;
    if (all_known) hold_next = hold_cnt + CNT_ONE;
  end

  // Per-signal sticky X history, cleared by an accepted start.
  for (genvar i = 0; i < N_SIG; i++) begin : g_track
    assign obs[i] = '{x: sig_x[i], val: sig_val[i]};

    x_sticky_tracker u_track (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (state == OBSERVE),
      .sig     (obs[i]),
      .x_seen  (x_seen_mask[i]),
      .relapse (relapse_mask[i])
    );
  end

  // Window FSM with counters and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_mask      <= '0;
      cyc_cnt       <= '0;
      hold_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      settled       <= 1'b0;
      settle_cycles <= '0;
      stuck_mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state         <= OBSERVE;
            busy          <= 1'b1;
            req_mask      <= must_settle;
            cyc_cnt       <= '0;
            hold_cnt      <= '0;
            settled       <= 1'b0;
            settle_cycles <= '0;
            stuck_mask    <= '0;
          end
        end
        OBSERVE: begin
          cyc_cnt  <= cyc_next;
          hold_cnt <= hold_next;
          // Settle wins over stuck when both happen on the same cycle.
          if (hold_next == HOLD_C) begin
            state         <= DONE;
            done          <= 1'b1;
            settled       <= 1'b1;
            settle_cycles <= cyc_next;
          end else if (cyc_next == LIMIT_C) begin
            state         <= DONE;
            done          <= 1'b1;
            settled       <= 1'b0;
            settle_cycles <= '0;
            stuck_mask    <= sig_x & req_mask;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_settle_monitor.sv
// Scoreboard bench for x_settle_monitor: stimulus pushes the expected result
// of each window, a monitor pops and compares whenever done is seen.
module tb_x_settle_monitor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] sig_val;
  logic [5:0] sig_x;
  logic [5:0] must_settle;
  logic       busy;
  logic       done;
  logic       settled;
  logic [7:0] settle_cycles;
  logic [5:0] stuck_mask;
  logic [5:0] x_seen_mask;
  logic [5:0] relapse_mask;

  typedef struct {
    logic       settled;
    logic [7:0] sc;
    logic [5:0] stuck;
    logic [5:0] xseen;
    logic [5:0] relapse;
    int         done_at;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] pat [0:31];
  int         pos_cnt  = 0;
  int         n_checks = 0;
  int         n_err    = 0;

  x_settle_monitor #(
    .N_SIG(6), .SETTLE_HOLD(2), .STUCK_LIMIT(16), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sig_val       (sig_val),
    .sig_x         (sig_x),
    .must_settle   (must_settle),
    .busy          (busy),
    .done          (done),
    .settled       (settled),
    .settle_cycles (settle_cycles),
    .stuck_mask    (stuck_mask),
    .x_seen_mask   (x_seen_mask),
    .relapse_mask  (relapse_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [7:0] sc, input logic [5:0] stuck,
                              input logic [5:0] xseen, input logic [5:0] rel);
    exp_t e;
    e.settled = s;
    e.sc      = sc;
    e.stuck   = stuck;
    e.xseen   = xseen;
    e.relapse = rel;
    e.done_at = 0;
    return e;
  endfunction

  // pat[i] is sig_x during observation cycle i.
  task automatic set_pat(input logic [5:0] early, input int upto, input logic [5:0] late);
    for (int i = 0; i < 32; i++) pat[i] = (i <= upto) ? early : late;
  endtask

  // Start a window; expected result is due k cycles after acceptance.
  task automatic do_window(input logic [5:0] mask, input int k, input int ncyc,
                           input bit keep_start, input bit push, input exp_t e);
    exp_t ee;
    ee = e;
    @(negedge clk);
    start       = 1'b1;
    must_settle = mask;
    sig_x       = pat[0];
    sig_val     = 6'($urandom);
    if (push) begin
      ee.done_at = pos_cnt + 1 + k;
      sb_q.push_back(ee);
    end
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (push) check($sformatf("busy_c%0d", i), 32'(busy), 32'(i <= k + 1));
      start       = keep_start;
      must_settle = 6'($urandom);
      sig_x       = pat[i];
      sig_val     = 6'($urandom);
    end
  endtask

  task automatic check_hold(input exp_t e);
    check("hold_busy",     32'(busy),          32'(1'b0));
    check("hold_settled",  32'(settled),       32'(e.settled));
    check("hold_sc",       32'(settle_cycles), 32'(e.sc));
    check("hold_stuck",    32'(stuck_mask),    32'(e.stuck));
    check("hold_xseen",    32'(x_seen_mask),   32'(e.xseen));
    check("hold_relapse",  32'(relapse_mask),  32'(e.relapse));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},    32'(busy),          32'(1'b0));
    check({tag, "_done"},    32'(done),          32'(1'b0));
    check({tag, "_settled"}, 32'(settled),       32'(1'b0));
    check({tag, "_sc"},      32'(settle_cycles), 32'(8'd0));
    check({tag, "_stuck"},   32'(stuck_mask),    32'(6'd0));
    check({tag, "_xseen"},   32'(x_seen_mask),   32'(6'd0));
    check({tag, "_relapse"}, 32'(relapse_mask),  32'(6'd0));
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result", pos_cnt);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle",  32'(pos_cnt),       32'(e.done_at));
        check("done_busy",   32'(busy),          32'(1'b1));
        check("settled",     32'(settled),       32'(e.settled));
        check("settle_cyc",  32'(settle_cycles), 32'(e.sc));
        check("stuck_mask",  32'(stuck_mask),    32'(e.stuck));
        check("x_seen_mask", 32'(x_seen_mask),   32'(e.xseen));
        check("relapse",     32'(relapse_mask),  32'(e.relapse));
      end
    end
  end

  initial begin
    exp_t e;
    rst         = 1'b1;
    start       = 1'b0;
    sig_val     = '0;
    sig_x       = '0;
    must_settle = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Stuck: all inputs X, two required -> timeout at cycle 16.
    set_pat(6'b111111, 31, 6'b111111);
    e = mk(1'b0, 8'd0, 6'b000011, 6'b111111, 6'b000000);
    do_window(6'b000011, 16, 19, 1'b0, 1'b1, e);
    check_hold(e);

    // Fast settle: required bit2 known from cycle 3 -> settles at 4.
    set_pat(6'b000100, 2, 6'b000000);
    e = mk(1'b1, 8'd4, 6'b000000, 6'b000100, 6'b000000);
    do_window(6'b000100, 4, 7, 1'b0, 1'b1, e);
    check_hold(e);

    // Relapse on required bit0 and non-required bit4 -> settles at 4.
    set_pat(6'b000000, 0, 6'b000000);
    pat[2] = 6'b010001;
    e = mk(1'b1, 8'd4, 6'b000000, 6'b010001, 6'b010001);
    do_window(6'b000001, 4, 7, 1'b0, 1'b1, e);
    check_hold(e);

    // Empty mask with everything X -> settles at SETTLE_HOLD.
    set_pat(6'b111111, 31, 6'b111111);
    e = mk(1'b1, 8'd2, 6'b000000, 6'b111111, 6'b000000);
    do_window(6'b000000, 2, 5, 1'b0, 1'b1, e);
    check_hold(e);

    // Reset after five observation cycles: no result, everything cleared.
    set_pat(6'b111111, 31, 6'b111111);
    do_window(6'b000011, 0, 5, 1'b0, 1'b0, e);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;

    // Fresh window after reset: settles at 3.
    set_pat(6'b110000, 1, 6'b000000);
    e = mk(1'b1, 8'd3, 6'b000000, 6'b110000, 6'b000000);
    do_window(6'b110000, 3, 6, 1'b0, 1'b1, e);
    check_hold(e);

    // Start held throughout window A; re-accepted in the IDLE cycle after DONE.
    set_pat(6'b000000, 0, 6'b000000);
    pat[2] = 6'b100010;
    e = mk(1'b1, 8'd4, 6'b000000, 6'b100010, 6'b100010);
    do_window(6'b000010, 4, 5, 1'b1, 1'b1, e);
    set_pat(6'b000011, 31, 6'b000011);
    e = mk(1'b0, 8'd0, 6'b000011, 6'b000011, 6'b000000);
    do_window(6'b000011, 16, 19, 1'b0, 1'b1, e);
    check_hold(e);

    repeat (3) @(negedge clk);
    check("pending_results", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/x_settle_monitor.md
Name: x_settle_monitor

Overview:
- Observation stage directly downstream of a simulated netlist module.
- Consumes that module's outputs as three-valued signals (value plus X flag).
- After a start request, decides whether the required outputs settle to known values or stay stuck at X.
- Reports settle latency, stuck signals, sticky X history and relapses (known back to X), so benches can check X-propagation behaviour without per-cycle inspection.

Parameters:
N_SIG, 6, number of monitored signals
SETTLE_HOLD, 2, consecutive cycles all required signals must be known to count as settled (>=1)
STUCK_LIMIT, 16, observation cycles before declaring stuck (>= SETTLE_HOLD, < 2**CNT_W)
CNT_W, 8, width of cycle counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin observation window; honoured only in IDLE
sig_val  in  N_SIG  signal values; bit ignored where sig_x is 1
sig_x  in  N_SIG  1 = corresponding signal is X
must_settle  in  N_SIG  mask of signals required to become known; sampled on accepted start
busy  out  1  high in OBSERVE and DONE
done  out  1  one-cycle pulse when a result is published
settled  out  1  1 = required signals settled; 0 = stuck
settle_cycles  out  CNT_W  observation cycle index at which hold completed; 0 if stuck
stuck_mask  out  N_SIG  required signals still X at timeout
x_seen_mask  out  N_SIG  sticky: signal was X on any observed cycle
relapse_mask  out  N_SIG  sticky: signal was known, then X again, within window

Behaviour:
- Reset (synchronous, active-high) returns the block to IDLE and zeroes every output and internal register. This includes mid-OBSERVE; no done pulse is issued.
- States are IDLE, OBSERVE and DONE.
- IDLE -> OBSERVE on start=1:
  - must_settle latched into req_mask.
  - cyc_cnt, hold_cnt, x_seen_mask, relapse_mask, known_once and stuck_mask cleared.
  - settled and settle_cycles cleared.
- OBSERVE, each cycle, using inputs present at that edge:
  - cyc_cnt increments; the first OBSERVE cycle has index 1.
  - x_seen_mask |= sig_x.
  - known_once |= ~sig_x.
  - relapse_mask |= known_once_prev & sig_x.
  - all_known = ((sig_x & req_mask) == 0).
  - hold_cnt = all_known ? hold_cnt+1 : 0.
- Settle: when hold_cnt reaches SETTLE_HOLD on cycle index k, go to DONE with settled=1 and settle_cycles=k.
- Stuck: otherwise, when cyc_cnt reaches STUCK_LIMIT, go to DONE with settled=0, settle_cycles=0, stuck_mask = sig_x & req_mask (that cycle's values).
- Settle takes priority if both conditions hold on the same cycle.
- DONE lasts exactly one cycle: done=1, then IDLE.
- Results and masks hold until the next accepted start or reset.
- start in OBSERVE or DONE is ignored; start in the IDLE cycle right after DONE is accepted.
- req_mask==0 settles at cycle SETTLE_HOLD, even if all signals are X.
- Non-required signals still update x_seen_mask and relapse_mask.
- sig_val is not compared to anything; it exists for debug visibility only and must not affect state.
- Counters never wrap, guaranteed by the STUCK_LIMIT bound. An elaboration-time check rejects illegal parameters.

Decomposition:
- Shared package: state enum (IDLE/OBSERVE/DONE) and a tri-value typedef {x, val} for encoding netlist outputs.
- One sub-module, x_sticky_tracker, holds the per-signal x_seen/known_once/relapse logic. It is replicated N_SIG wide and has clear/enable inputs.
- FSM and counters stay in the top.

Test Plan:
- Stuck case: sig_x=6'b111111 constantly, req_mask=6'b000011, start -> done at observation cycle 16, settled=0, stuck_mask=6'b000011, x_seen_mask=6'b111111, relapse_mask=0.
- Fast settle: sig_x goes from 6'b000100 to 6'b000000 on cycle 3, req_mask=6'b000100 -> settled=1 with settle_cycles=4 (SETTLE_HOLD=2), done on the cycle after.
- Relapse: req bit0 known on cycle 1, X on cycle 2, known from cycle 3 onward -> relapse_mask[0]=1, settled=1, settle_cycles=4.
- Empty mask: req_mask=0, all inputs X -> settled=1, settle_cycles=2, x_seen_mask all ones.
- Reset mid-OBSERVE at cycle 5 -> next cycle IDLE, all outputs 0, no done pulse. A new start afterwards behaves as a fresh window.
- Start while busy, asserted every cycle -> only the first is accepted. A back-to-back start in the IDLE cycle after DONE is accepted, and the previous results are cleared.
